// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;
    localparam int unsigned ZERO_REG = 0;

    typedef logic [$clog2(NREG_DEF)-1:0] reg_addr_t;
    typedef logic [XLEN_DEF-1:0]         xword_t;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by reserve, cleared by write.
module regfile_mp_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    output logic [NREG-1:0] busy_vec
);

    logic [NREG-1:0] busy_q, busy_d;

    // Reserve is applied after the clear: it belongs to a newer producer.
    always_comb begin
        busy_d = busy_q;
        if (we) begin
            busy_d[waddr] = 1'b0;
        end
        if (rsv_en && (rsv_addr != AW'(ZERO_REG))) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with x0 hardwired to zero and a pending-write scoreboard.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data/busy to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned AW     = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [XLEN-1:0]        wdata,
    input  logic                   rsv_en,
    input  logic [AW-1:0]          rsv_addr,
    output logic [NREG-1:0]        busy_vec
);

    logic [XLEN-1:0] regs_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != AW'(ZERO_REG))) begin
            regs_q[waddr] <= wdata;
        end
    end

    regfile_mp_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_vec (busy_vec)
    );

`ifdef REGFILE_MP_BYPASS_EN
    logic wr_fwd;
    // Gated by rst_n so reads stay zero while reset is held.
    assign wr_fwd = rst_n && we && (waddr != AW'(ZERO_REG));
`endif

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            busy;

        assign addr = rd_addr[i*AW +: AW];

        always_comb begin
            data = (addr == AW'(ZERO_REG)) ? '0 : regs_q[addr];
            busy = busy_vec[addr];
`ifdef REGFILE_MP_BYPASS_EN
            if (wr_fwd && (addr == waddr)) begin
                data = wdata;
                busy = rsv_en && (rsv_addr == waddr);
            end
`endif
        end

        assign rd_data[i*XLEN +: XLEN] = data;
        assign rd_busy[i]              = busy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against a behavioural model,
// covering the default-width 3-port build and a 64-bit/16-reg/1-port build.
module tb_regfile_mp;

`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // DUT A: XLEN=32, NREG=32, NUM_RD=3
    logic [14:0] a_rd_addr;
    logic [95:0] a_rd_data;
    logic [2:0]  a_rd_busy;
    logic        a_we, a_rsv_en;
    logic [4:0]  a_waddr, a_rsv_addr;
    logic [31:0] a_wdata;
    logic [31:0] a_busy_vec;

    // DUT B: XLEN=64, NREG=16, NUM_RD=1
    logic [3:0]  b_rd_addr;
    logic [63:0] b_rd_data;
    logic [0:0]  b_rd_busy;
    logic        b_we, b_rsv_en;
    logic [3:0]  b_waddr, b_rsv_addr;
    logic [63:0] b_wdata;
    logic [15:0] b_busy_vec;

    regfile_mp #(.XLEN(32), .NREG(32), .NUM_RD(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .rd_busy(a_rd_busy), .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
        .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr), .busy_vec(a_busy_vec)
    );

    regfile_mp #(.XLEN(64), .NREG(16), .NUM_RD(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
        .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr), .busy_vec(b_busy_vec)
    );

    // Behavioural model
    logic [31:0] ma_mem [32];
    logic [31:0] ma_busy;
    logic [63:0] mb_mem [16];
    logic [15:0] mb_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) ma_mem[i] <= '0;
            for (int i = 0; i < 16; i++) mb_mem[i] <= '0;
            ma_busy <= '0;
            mb_busy <= '0;
        end else begin
            logic [31:0] na;
            logic [15:0] nb;
            if (a_we && a_waddr != 0) ma_mem[a_waddr] <= a_wdata;
            if (b_we && b_waddr != 0) mb_mem[b_waddr] <= b_wdata;
            na = ma_busy;
            if (a_we) na[a_waddr] = 1'b0;
            if (a_rsv_en && a_rsv_addr != 0) na[a_rsv_addr] = 1'b1;
            nb = mb_busy;
            if (b_we) nb[b_waddr] = 1'b0;
            if (b_rsv_en && b_rsv_addr != 0) nb[b_rsv_addr] = 1'b1;
            ma_busy <= na;
            mb_busy <= nb;
        end
    end

    function automatic logic [31:0] expa_data(input logic [4:0] a);
        if (!rst_n || a == 0) return '0;
        if (BYP && a_we && a_waddr == a) return a_wdata;
        return ma_mem[a];
    endfunction

    function automatic logic expa_busy(input logic [4:0] a);
        if (!rst_n || a == 0) return 1'b0;
        if (BYP && a_we && a_waddr == a) return a_rsv_en && (a_rsv_addr == a);
        return ma_busy[a];
    endfunction

    function automatic logic [63:0] expb_data(input logic [3:0] a);
        if (!rst_n || a == 0) return '0;
        if (BYP && b_we && b_waddr == a) return b_wdata;
        return mb_mem[a];
    endfunction

    function automatic logic expb_busy(input logic [3:0] a);
        if (!rst_n || a == 0) return 1'b0;
        if (BYP && b_we && b_waddr == a) return b_rsv_en && (b_rsv_addr == a);
        return mb_busy[a];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int p = 0; p < 3; p++) begin
                chk("a_rd_data", 64'(a_rd_data[p*32 +: 32]), 64'(expa_data(a_rd_addr[p*5 +: 5])));
                chk("a_rd_busy", 64'(a_rd_busy[p]), 64'(expa_busy(a_rd_addr[p*5 +: 5])));
            end
            chk("a_busy_vec", 64'(a_busy_vec), rst_n ? 64'(ma_busy) : 64'd0);
            chk("b_rd_data", b_rd_data, expb_data(b_rd_addr));
            chk("b_rd_busy", 64'(b_rd_busy[0]), 64'(expb_busy(b_rd_addr)));
            chk("b_busy_vec", 64'(b_busy_vec), rst_n ? 64'(mb_busy) : 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_we = 1'b0; a_rsv_en = 1'b0; a_waddr = '0; a_rsv_addr = '0; a_wdata = '0;
        b_we = 1'b0; b_rsv_en = 1'b0; b_waddr = '0; b_rsv_addr = '0; b_wdata = '0;
    endtask

    task automatic a_write(input logic [4:0] ad, input logic [31:0] d);
        a_we = 1'b1; a_waddr = ad; a_wdata = d;
    endtask

    initial begin
        idle();
        a_rd_addr = '0;
        b_rd_addr = '0;
        tick();
        tick();
        chk_en = 1'b1;
        chk("reset_busy_vec", 64'(a_busy_vec), 64'd0);
        chk("reset_rd_data", 64'(a_rd_data), 64'd0);
        rst_n = 1'b1;

        // Basic write/read on three ports
        a_write(5'd1, 32'h11); tick();
        a_write(5'd2, 32'h22); tick();
        a_write(5'd3, 32'h33); tick();
        idle();
        a_rd_addr = {5'd3, 5'd2, 5'd1};
        #1;
        chk("read_p0", 64'(a_rd_data[31:0]), 64'h11);
        chk("read_p1", 64'(a_rd_data[63:32]), 64'h22);
        chk("read_p2", 64'(a_rd_data[95:64]), 64'h33);
        chk("model_x2", 64'(ma_mem[2]), 64'h22);

        // Writes to x0 are dropped
        a_rd_addr = {5'd0, 5'd0, 5'd0};
        a_write(5'd0, 32'hFFFF_FFFF);
        #1;
        chk("x0_same_cycle", 64'(a_rd_data[31:0]), 64'd0);
        tick();
        idle();
        #1;
        chk("x0_after", 64'(a_rd_data[31:0]), 64'd0);

        // Reserve x9, hold three idle cycles
        a_rsv_en = 1'b1; a_rsv_addr = 5'd9;
        a_rd_addr = {5'd9, 5'd9, 5'd9};
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("x9_busy", 64'(a_rd_busy), 64'h7);
            tick();
        end
        a_write(5'd9, 32'hA5);
        #1;
        chk("x9_wr_busy", 64'(a_rd_busy[0]), BYP ? 64'd0 : 64'd1);
        chk("x9_wr_data", 64'(a_rd_data[31:0]), BYP ? 64'hA5 : 64'd0);
        tick();
        idle();
        #1;
        chk("x9_released", 64'(a_rd_busy), 64'd0);
        chk("x9_data", 64'(a_rd_data[31:0]), 64'hA5);

        // Reserving x0 has no effect
        a_rsv_en = 1'b1; a_rsv_addr = 5'd0;
        tick();
        idle();
        #1;
        chk("x0_never_busy", 64'(a_busy_vec), 64'd0);

        // Same-cycle write and reserve of x4
        a_write(5'd4, 32'h44);
        a_rsv_en = 1'b1; a_rsv_addr = 5'd4;
        a_rd_addr = {5'd6, 5'd0, 5'd4};
        tick();
        idle();
        #1;
        chk("wr_rsv_same_busy", 64'(a_busy_vec[4]), 64'd1);
        chk("wr_rsv_same_data", 64'(a_rd_data[31:0]), 64'h44);
        chk("model_busy4", 64'(ma_busy), 64'h10);

        // Write x4 and reserve x6 together
        a_write(5'd4, 32'h45);
        a_rsv_en = 1'b1; a_rsv_addr = 5'd6;
        tick();
        idle();
        #1;
        chk("wr_rsv_diff_b4", 64'(a_busy_vec[4]), 64'd0);
        chk("wr_rsv_diff_b6", 64'(a_busy_vec[6]), 64'd1);
        chk("wr_rsv_diff_d4", 64'(a_rd_data[31:0]), 64'h45);

        // Write x12 while port 0 reads it
        a_rd_addr = {5'd0, 5'd0, 5'd12};
        a_write(5'd12, 32'h1234);
        #1;
        chk("bypass_same", 64'(a_rd_data[31:0]), BYP ? 64'h1234 : 64'd0);
        tick();
        idle();
        #1;
        chk("bypass_next", 64'(a_rd_data[31:0]), 64'h1234);

        // Reset mid-run after writing x5 and reserving x7
        a_write(5'd5, 32'hDEAD_BEEF);
        a_rsv_en = 1'b1; a_rsv_addr = 5'd7;
        a_rd_addr = {5'd0, 5'd7, 5'd5};
        tick();
        idle();
        #1;
        chk("pre_reset_x5", 64'(a_rd_data[31:0]), 64'hDEAD_BEEF);
        chk("pre_reset_b7", 64'(a_busy_vec[7]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_x5", 64'(a_rd_data[31:0]), 64'd0);
        chk("async_reset_busy", 64'(a_busy_vec), 64'd0);
        a_write(5'd5, 32'h5555_5555);
        a_rsv_en = 1'b1; a_rsv_addr = 5'd7;
        tick();
        #1;
        chk("reset_held_x5", 64'(a_rd_data[31:0]), 64'd0);
        chk("reset_held_busy", 64'(a_busy_vec), 64'd0);
        idle();
        rst_n = 1'b1;
        tick();

        // 64-bit / 16-register / single-port build
        b_rd_addr = 4'd15;
        b_we = 1'b1; b_waddr = 4'd15; b_wdata = 64'h0123_4567_89AB_CDEF;
        tick();
        idle();
        #1;
        chk("b_x15", b_rd_data, 64'h0123_4567_89AB_CDEF);
        for (int r = 0; r < 16; r++) begin
            b_rsv_en = 1'b1; b_rsv_addr = 4'(r);
            tick();
        end
        idle();
        #1;
        chk("b_all_busy", 64'(b_busy_vec), 64'hFFFE);
        chk("model_b_all_busy", 64'(mb_busy), 64'hFFFE);
        for (int r = 0; r < 16; r++) begin
            b_we = 1'b1; b_waddr = 4'(r); b_wdata = 64'(r) << 32;
            tick();
        end
        idle();
        #1;
        chk("b_all_released", 64'(b_busy_vec), 64'd0);

        // Random traffic, narrow address range to provoke collisions
        for (int i = 0; i < 600; i++) begin
            a_we       = 1'($urandom_range(0, 1));
            a_waddr    = 5'($urandom_range(0, 15));
            a_wdata    = $urandom;
            a_rsv_en   = ($urandom_range(0, 2) == 0);
            a_rsv_addr = 5'($urandom_range(0, 15));
            a_rd_addr  = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                          5'($urandom_range(0, 15))};
            b_we       = 1'($urandom_range(0, 1));
            b_waddr    = 4'($urandom_range(0, 15));
            b_wdata    = {$urandom, $urandom};
            b_rsv_en   = ($urandom_range(0, 2) == 0);
            b_rsv_addr = 4'($urandom_range(0, 15));
            b_rd_addr  = 4'($urandom_range(0, 15));
            if ((i % 10) == 0) a_rd_addr[4:0] = a_waddr;
            if ((i % 7) == 0) b_rd_addr = b_waddr;
            if (i == 300) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("rand_async_reset_a", 64'(a_busy_vec), 64'd0);
                chk("rand_async_reset_b", b_rd_data, 64'd0);
            end
            tick();
            if (i == 300) rst_n = 1'b1;
        end

        idle();
        tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file with a pending-write scoreboard. It replaces the fixed 32×32, two-read-port register file in the single-cycle core and adds capabilities needed for a multi-cycle or pipelined datapath: a configurable read-port count, asynchronous clearing reset, and per-register busy tracking for long-latency producers such as a divider or load unit. Register 0 is hardwired to zero.

## Interface
Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers; power of two, 2..64.
- NUM_RD, 2, number of read ports; range 1..4.
- AW, $clog2(NREG), address width. Derived; never overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NUM_RD*XLEN  packed read data; combinational from rd_addr.
- rd_busy  out  NUM_RD  busy flag of the addressed register, per port; combinational.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  XLEN  write data.
- rsv_en  in  1  reserve request: mark rsv_addr as having a pending write.
- rsv_addr  in  AW  register to reserve.
- busy_vec  out  NREG  full scoreboard, for the hazard unit.

## Operation
- Storage: NREG×XLEN array. Read ports are asynchronous: rd_data[i] = x[rd_addr[i]].
- Write: on a clk edge with we=1 and waddr≠0, x[waddr] ← wdata. When we=0, no register changes.
- x0: reads always return 0. Writes to x0 are dropped. x0 is never busy.
- Scoreboard: one busy bit per register.
  - rsv_en=1 with rsv_addr≠0 sets busy[rsv_addr].
  - we=1 clears busy[waddr], whether or not the register was reserved.
- Same-cycle reserve and write to the same register: the bit ends at 1, because the reservation is for a newer producer.
- Reserve and write to different registers in the same cycle: both take effect.
- A reserve of an already-busy register leaves it busy. There is no counting; only one outstanding producer per register is allowed.
- rd_busy[i] = busy[rd_addr[i]].
- Reset (rst_n=0, asynchronous): all registers become 0 and all busy bits become 0.
  - While rst_n is held low, rd_data = 0, rd_busy = 0 and busy_vec = 0, and writes and reserves are ignored.
  - A reset asserted mid-operation discards pending reservations without notification.

## Timing
- Read latency: 0 cycles (combinational). Write-to-read latency without bypass: visible from the cycle after the write edge.
- Scoreboard update latency: 1 edge. rd_busy and busy_vec reflect a reservation from the cycle after rsv_en was sampled.
- Reset is asserted asynchronously. Release is synchronous to clk; the first write is accepted on the first edge with rst_n=1.
- No handshake back-pressure. Every we and rsv_en is accepted on the edge where it is sampled high.

## Configuration
- Macro: REGFILE_MP_BYPASS_EN.
- Defined: write-to-read forwarding. If we=1, waddr≠0 and rd_addr[i]=waddr in the same cycle:
  - rd_data[i] = wdata.
  - rd_busy[i] = 0, unless rsv_en=1 with rsv_addr=waddr in the same cycle, in which case rd_busy[i] = 1.
- Not defined: reads return the pre-write array value and the stored busy bit. The consumer sees the new data one cycle later.
- busy_vec is never bypassed in either configuration.

## Structure
- Package regfile_pkg holds:
  - XLEN_DEF = 32 and NREG_DEF = 32.
  - The reg_addr_t / xword_t typedefs for the default configuration.
  - The constant ZERO_REG = 0.
- Sub-module regfile_mp_scoreboard contains the NREG busy bits, the set/clear priority logic and busy_vec. The top level holds the storage array, the read muxes and the bypass logic.

## Test plan
- Reset:
  - Assert rst_n=0 mid-run after writing x5=0xDEADBEEF and reserving x7.
  - Expect rd_data=0 for x5 and busy_vec=0, immediately and asynchronously.
- Basic write/read with NUM_RD=3:
  - Write x1=0x11, x2=0x22, x3=0x33.
  - Read ports {1,2,3} → 0x11/0x22/0x33.
  - Write x0=0xFFFF_FFFF; reading x0 returns 0.
- Scoreboard:
  - Reserve x9, then hold 3 idle cycles: rd_busy=1 at ports addressing x9.
  - Write x9=0xA5 → busy clears the next cycle and the data reads 0xA5.
  - Reserving x0 never sets busy_vec[0].
- Simultaneous events:
  - Same cycle: we with waddr=4 and rsv_en with rsv_addr=4 → busy[4]=1 and x4 updated.
  - Same cycle: write x4 and reserve x6 → busy[4]=0, busy[6]=1.
- Bypass, in both builds: write x12=0x1234 while port 0 reads x12.
  - With REGFILE_MP_BYPASS_EN: 0x1234 in the same cycle.
  - Without: old value, then 0x1234 the next cycle.
- Parametrisation: instantiate XLEN=64, NREG=16, NUM_RD=1.
  - Write x15=0x0123_4567_89AB_CDEF and read it back.
  - Reserve and release every register; busy_vec returns to all zeros.
